// File: rtl/dvi_timing_ctrl_if.sv
// Raster timing bundle between the timing controller and the pixel source / TMDS encoders.
interface dvi_timing_ctrl_if;
  logic       enable;
  logic       hsync;
  logic       vsync;
  logic       de;
  logic [9:0] x;
  logic [9:0] y;
  logic       line_start;
  logic       frame_start;
  logic       running;

  modport master (
    input  enable,
    output hsync, vsync, de, x, y, line_start, frame_start, running
  );

  modport slave (
    output enable,
    input  hsync, vsync, de, x, y, line_start, frame_start, running
  );
endinterface

// File: rtl/dvi_timing_ctrl.sv
// Pixel-clock raster generator: sync/de/coordinates plus start/stop sequencing
// that only ever stops at a frame boundary.
module dvi_timing_ctrl #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic              pixclk,
  input  logic              reset,
  dvi_timing_ctrl_if.master vid
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Region bounds kept 11 bits wide so a 1024-slot raster cannot overflow them.
  localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYN_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYN_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYN_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYN_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [9:0]  r_hc;
  logic [9:0]  r_vc;
  logic [9:0]  w_hc_nxt;
  logic [9:0]  w_vc_nxt;
  logic [10:0] w_hc_ext;
  logic [10:0] w_vc_ext;
  logic        w_counting;
  logic        w_h_last;
  logic        w_frame_last;
  logic        w_h_act;
  logic        w_v_act;
  logic        w_h_syn;
  logic        w_v_syn;
  logic        w_de;
  logic        w_hsync;
  logic        w_vsync;
  logic [9:0]  w_x;
  logic [9:0]  w_y;
  logic        w_line_start;
  logic        w_frame_start;
  logic        w_running;

  logic        r_hsync;
  logic        r_vsync;
  logic        r_de;
  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic        r_line_start;
  logic        r_frame_start;
  logic        r_running;

  assign w_counting   = (r_state != S_IDLE);
  assign w_h_last     = (r_hc == H_LAST);
  assign w_frame_last = w_h_last && (r_vc == V_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (vid.enable) w_state_nxt = S_RUN;
      S_RUN:   if (!vid.enable) w_state_nxt = w_frame_last ? S_IDLE : S_DRAIN;
      S_DRAIN: begin
        if (vid.enable)        w_state_nxt = S_RUN;
        else if (w_frame_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_hc_nxt = '0;
    w_vc_nxt = '0;
    if (w_counting) begin
      if (w_h_last) begin
        w_hc_nxt = '0;
        w_vc_nxt = w_frame_last ? '0 : r_vc + 10'd1;
      end else begin
        w_hc_nxt = r_hc + 10'd1;
        w_vc_nxt = r_vc;
      end
    end
  end

  // Outputs are decoded from the current counters and registered, so every
  // output trails the counters by exactly one cycle with no relative skew.
  always_comb begin
    w_hc_ext      = {1'b0, r_hc};
    w_vc_ext      = {1'b0, r_vc};
    w_h_act       = (w_hc_ext < H_ACT_END);
    w_v_act       = (w_vc_ext < V_ACT_END);
    w_h_syn       = (w_hc_ext >= H_SYN_BEG) && (w_hc_ext < H_SYN_END);
    w_v_syn       = (w_vc_ext >= V_SYN_BEG) && (w_vc_ext < V_SYN_END);
    w_de          = w_counting && w_h_act && w_v_act;
    w_hsync       = (w_counting && w_h_syn) ? HSYNC_POL : !HSYNC_POL;
    w_vsync       = (w_counting && w_v_syn) ? VSYNC_POL : !VSYNC_POL;
    w_x           = w_de ? r_hc : '0;
    w_y           = w_de ? r_vc : '0;
    w_line_start  = w_counting && (r_hc == '0);
    w_frame_start = w_line_start && (r_vc == '0);
    // Held through the final slot of a drained frame so it falls with the outputs.
    w_running     = w_counting || (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge pixclk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_hc          <= '0;
      r_vc          <= '0;
      r_hsync       <= !HSYNC_POL;
      r_vsync       <= !VSYNC_POL;
      r_de          <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_running     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_hc          <= w_hc_nxt;
      r_vc          <= w_vc_nxt;
      r_hsync       <= w_hsync;
      r_vsync       <= w_vsync;
      r_de          <= w_de;
      r_x           <= w_x;
      r_y           <= w_y;
      r_line_start  <= w_line_start;
      r_frame_start <= w_frame_start;
      r_running     <= w_running;
    end
  end

  assign vid.hsync       = r_hsync;
  assign vid.vsync       = r_vsync;
  assign vid.de          = r_de;
  assign vid.x           = r_x;
  assign vid.y           = r_y;
  assign vid.line_start  = r_line_start;
  assign vid.frame_start = r_frame_start;
  assign vid.running     = r_running;
endmodule

// File: tb/tb_dvi_timing_ctrl.sv
// Bench for dvi_timing_ctrl: three rasters (default, medium, tiny active-high)
// checked every cycle against a linear-position frame model plus literal timing pins.
module tb_dvi_timing_ctrl;
  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit hp, vp;
  } geom_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;

  always #5 clk = ~clk;

  dvi_timing_ctrl_if if0 ();
  dvi_timing_ctrl_if if1 ();
  dvi_timing_ctrl_if if2 ();
  assign if0.enable = en;
  assign if1.enable = en;
  assign if2.enable = en;

  dvi_timing_ctrl u_dut0 (.pixclk(clk), .reset(rst), .vid(if0.master));

  dvi_timing_ctrl #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_dut1 (.pixclk(clk), .reset(rst), .vid(if1.master));

  dvi_timing_ctrl #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) u_dut2 (.pixclk(clk), .reset(rst), .vid(if2.master));

  // {hsync, vsync, de, x[9:0], y[9:0], line_start, frame_start, running}
  logic [25:0] act [3];
  assign act[0] = {if0.hsync, if0.vsync, if0.de, if0.x, if0.y, if0.line_start, if0.frame_start, if0.running};
  assign act[1] = {if1.hsync, if1.vsync, if1.de, if1.x, if1.y, if1.line_start, if1.frame_start, if1.running};
  assign act[2] = {if2.hsync, if2.vsync, if2.de, if2.x, if2.y, if2.line_start, if2.frame_start, if2.running};

  int n_assert = 0;
  int n_fail   = 0;
  int n_print  = 0;
  int cyc      = 0;
  bit chk_on   = 1'b0;

  function automatic geom_t geom_of(input int d);
    geom_t q;
    case (d)
      1:       q = '{64, 4, 8, 4, 48, 2, 2, 3, 1'b0, 1'b0};
      2:       q = '{8, 2, 3, 2, 4, 1, 2, 1, 1'b1, 1'b1};
      default: q = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    endcase
    return q;
  endfunction

  // Output expected for linear frame position pos (pos = line * H_TOTAL + column).
  function automatic logic [25:0] model_out(input geom_t q, input int pos);
    int ht, h, v;
    bit hs_a, vs_a, de_a;
    logic [9:0] xx, yy;
    ht   = q.ha + q.hf + q.hs + q.hb;
    h    = pos % ht;
    v    = pos / ht;
    hs_a = (h >= q.ha + q.hf) && (h < q.ha + q.hf + q.hs);
    vs_a = (v >= q.va + q.vf) && (v < q.va + q.vf + q.vs);
    de_a = (h < q.ha) && (v < q.va);
    xx   = de_a ? h[9:0] : 10'd0;
    yy   = de_a ? v[9:0] : 10'd0;
    return {hs_a ? q.hp : !q.hp, vs_a ? q.vp : !q.vp, de_a, xx, yy, h == 0, pos == 0, 1'b1};
  endfunction

  function automatic logic [25:0] idle_out(input geom_t q);
    return {!q.hp, !q.vp, 24'd0};
  endfunction

  // Reference model: a raster is either off or at a position in its frame; it
  // may only leave the frame at the last position, and only if enable is low there.
  bit          m_on  [3];
  int          m_pos [3];
  logic [25:0] m_exp [3];

  initial begin
    geom_t q;
    int    frame;
    bit    stopping;
    forever begin
      @(posedge clk);
      for (int d = 0; d < 3; d++) begin
        q     = geom_of(d);
        frame = (q.ha + q.hf + q.hs + q.hb) * (q.va + q.vf + q.vs + q.vb);
        if (rst) begin
          m_on[d]  = 1'b0;
          m_pos[d] = 0;
          m_exp[d] = idle_out(q);
        end else begin
          stopping = m_on[d] && (m_pos[d] == frame - 1) && !en;
          m_exp[d] = m_on[d] ? model_out(q, m_pos[d]) : idle_out(q);
          if (stopping) begin
            m_on[d]  = 1'b0;
            m_pos[d] = 0;
          end else if (m_on[d]) begin
            m_pos[d] = (m_pos[d] + 1) % frame;
          end else if (en) begin
            m_on[d] = 1'b1;
          end
          m_exp[d][0] = m_on[d] || stopping;
        end
      end
      chk_on = 1'b1;
    end
  end

  // Per-frame statistics gathered from the DUT outputs for the literal checks.
  int fs_cnt [3], fs_cyc [3], rf_cyc [3];
  int acc_de [3], acc_ls [3], acc_vs [3], acc_hs [3], last_x [3], last_y [3];
  int p_period [3], p_de [3], p_ls [3], p_vs [3], p_hs [3], p_x [3], p_y [3];
  bit fs_seen [3], prev_run [3], run_low [3];
  int ls0_cyc, l0_period, l0_de, de0_acc, h0_beg, h0_off, h0_w;
  bit ls0_seen = 1'b0;
  bit prev_h0  = 1'b1;

  initial begin
    geom_t q;
    forever begin
      @(negedge clk);
      cyc++;
      if (chk_on) begin
        for (int d = 0; d < 3; d++) begin
          n_assert++;
          if (act[d] !== m_exp[d]) begin
            n_fail++;
            if (n_print < 20) begin
              n_print++;
              $display("FAIL cycle_cmp dut%0d cycle %0d: got %h, expected %h", d, cyc, act[d], m_exp[d]);
            end
          end
        end
      end
      for (int d = 0; d < 3; d++) begin
        q = geom_of(d);
        if (rst) fs_seen[d] = 1'b0;
        if (act[d][1] === 1'b1) begin
          if (fs_seen[d]) begin
            p_period[d] = cyc - fs_cyc[d];
            p_de[d] = acc_de[d];  p_ls[d] = acc_ls[d];
            p_vs[d] = acc_vs[d];  p_hs[d] = acc_hs[d];
            p_x[d]  = last_x[d];  p_y[d]  = last_y[d];
          end
          fs_seen[d] = 1'b1;
          fs_cyc[d]  = cyc;
          fs_cnt[d]++;
          acc_de[d] = 0; acc_ls[d] = 0; acc_vs[d] = 0; acc_hs[d] = 0;
        end
        acc_de[d] += int'(act[d][23] === 1'b1);
        acc_ls[d] += int'(act[d][2] === 1'b1);
        acc_vs[d] += int'(act[d][24] === q.vp);
        acc_hs[d] += int'(act[d][25] === q.hp);
        if (act[d][23] === 1'b1) begin
          last_x[d] = int'(act[d][22:13]);
          last_y[d] = int'(act[d][12:3]);
        end
        if (prev_run[d] && act[d][0] !== 1'b1) rf_cyc[d] = cyc;
        if (act[d][0] !== 1'b1) run_low[d] = 1'b1;
        prev_run[d] = (act[d][0] === 1'b1);
      end
      if (act[0][2] === 1'b1) begin
        if (ls0_seen) begin
          l0_period = cyc - ls0_cyc;
          l0_de     = de0_acc;
        end
        ls0_seen = 1'b1;
        ls0_cyc  = cyc;
        de0_acc  = 0;
      end
      de0_acc += int'(act[0][23] === 1'b1);
      if (prev_h0 && act[0][25] === 1'b0) begin
        h0_off = cyc - ls0_cyc;
        h0_beg = cyc;
      end
      if (!prev_h0 && act[0][25] === 1'b1) h0_w = cyc - h0_beg;
      prev_h0 = (act[0][25] !== 1'b0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic wait_fs(input int d, input int budget);
    int start, n;
    start = fs_cnt[d];
    n = 0;
    while (fs_cnt[d] == start && n < budget) begin
      tick(1);
      n++;
    end
    n_assert++;
    if (fs_cnt[d] == start) begin
      n_fail++;
      $display("FAIL wait_fs dut%0d: got no frame_start in %0d cycles, expected one", d, budget);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no end of test by cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  // Medium raster (dut1) stands in for the default raster in the frame-level
  // scenarios: 80 x 55 slots, 4400 cycles per frame; lines 18/35/30 replace 100/300/200.
  initial begin
    int n, ls_hold, fs_hold;
    tick(5);
    check("reset_dut0", act[0], 32'h3000000);
    check("reset_dut1", act[1], 32'h3000000);
    check("reset_dut2", act[2], 32'h0000000);
    rst = 1'b0;
    tick(1);
    check("release_e1_dut1", act[1], 32'h3000001);
    check("release_e1_dut2", act[2], 32'h0000001);
    tick(1);
    check("first_fs_dut0", act[0], 32'h3800007);
    check("first_fs_dut1", act[1], 32'h3800007);
    check("first_fs_dut2", act[2], 32'h0800007);

    tick(2000);
    check("line_period_dut0", l0_period, 800);
    check("line_de_dut0", l0_de, 640);
    check("hsync_offset_dut0", h0_off, 656);
    check("hsync_width_dut0", h0_w, 96);

    wait_fs(1, 5000);
    check("frame_period_dut1", p_period[1], 4400);
    check("frame_de_dut1", p_de[1], 3072);
    check("frame_ls_dut1", p_ls[1], 55);
    check("frame_vsync_dut1", p_vs[1], 160);
    check("frame_hsync_dut1", p_hs[1], 440);
    check("last_x_dut1", p_x[1], 63);
    check("last_y_dut1", p_y[1], 47);
    check("frame_period_dut2", p_period[2], 120);
    check("frame_de_dut2", p_de[2], 32);
    check("frame_vsync_dut2", p_vs[2], 30);
    check("frame_hsync_dut2", p_hs[2], 24);
    check("last_xy_dut2", {p_x[2][15:0], p_y[2][15:0]}, {16'd7, 16'd3});

    // Stop request mid-frame: the frame completes, then everything goes quiet.
    tick(18 * 80);
    en = 1'b0;
    n = 0;
    while (act[1][0] === 1'b1 && n < 6000) begin
      tick(1);
      n++;
    end
    check("stop_running_fall_dut1", rf_cyc[1] - fs_cyc[1], 4400);
    fs_hold = fs_cnt[1];
    ls_hold = acc_ls[1];
    tick(300);
    check("stop_no_fs_dut1", fs_cnt[1], fs_hold);
    check("stop_no_ls_dut1", acc_ls[1], ls_hold);
    check("stop_idle_dut1", act[1], 32'h3000000);

    // Re-enable while draining: no gap in the raster, running never drops.
    en = 1'b1;
    wait_fs(1, 100);
    run_low[1] = 1'b0;
    tick(18 * 80);
    en = 1'b0;
    tick(17 * 80);
    en = 1'b1;
    wait_fs(1, 5000);
    check("redrain_period_dut1", p_period[1], 4400);
    check("redrain_running_dut1", run_low[1], 0);

    // Reset mid-frame with enable held high.
    tick(30 * 80);
    rst = 1'b1;
    tick(1);
    check("midreset_idle_dut1", act[1], 32'h3000000);
    check("midreset_idle_dut2", act[2], 32'h0000000);
    rst = 1'b0;
    tick(1);
    check("midreset_e1_dut1", act[1], 32'h3000001);
    tick(1);
    check("midreset_fs_dut1", act[1], 32'h3800007);

    // Random enable activity with occasional resets; the model checks every cycle.
    for (int i = 0; i < 40; i++) begin
      en = 1'($urandom_range(0, 1));
      tick(int'($urandom_range(1, 1500)));
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        tick(int'($urandom_range(1, 3)));
        rst = 1'b0;
      end
    end
    tick(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/dvi_timing_ctrl.md
# dvi_timing_ctrl

Video timing controller that sequences the DVI/TMDS output path on the 25 MHz pixel clock. It generates hsync, vsync, data-enable and pixel coordinates for a parameterised raster (default 640x480@60, 800x525 total). It also provides start/stop sequencing so the TMDS encoders never see a truncated frame. It sits between the clock block's pixel clock and the pixel source/TMDS encoder inputs.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of hsync (0 = active low)
- VSYNC_POL, 0, asserted level of vsync (0 = active low)

Ports:
- pixclk  in  1  pixel clock; the only clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  request video output; level-sensitive
- hsync  out  1  horizontal sync, polarity per HSYNC_POL
- vsync  out  1  vertical sync, polarity per VSYNC_POL
- de  out  1  data enable: high during active pixels
- x  out  10  pixel column; valid when de=1
- y  out  10  pixel row; valid when de=1
- line_start  out  1  one-cycle pulse on the first pixel slot of every line
- frame_start  out  1  one-cycle pulse on pixel (0,0) of every frame
- running  out  1  high while the controller is in RUN or DRAIN

## Operation
- Internal counters hc (0..H_TOTAL-1) and vc (0..V_TOTAL-1). H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL is the vertical equivalent; both must be ≤1024. hc wraps to 0 at H_TOTAL-1. vc increments on each hc wrap and wraps to 0 at V_TOTAL-1 with hc=H_TOTAL-1.
- Horizontal regions:
  - active: hc < H_ACTIVE
  - sync: H_ACTIVE+H_FP ≤ hc < H_ACTIVE+H_FP+H_SYNC
  - the remainder is porch
- Vertical regions use the same rule with vc. vsync changes only at hc=0.
- de = h_active AND v_active. x = hc and y = vc when de=1; both are 0 when de=0.
- State machine:
  - IDLE: counters held at 0. hsync=~HSYNC_POL, vsync=~VSYNC_POL, de=0, pulses 0, running=0.
  - IDLE -> RUN when enable=1 is sampled. Counters start at (0,0) on the next cycle.
  - RUN -> DRAIN when enable=0 is sampled. Counting continues unchanged.
  - DRAIN -> RUN when enable=1 is sampled. There is no raster disturbance.
  - DRAIN -> IDLE on the cycle the counter is at (H_TOTAL-1, V_TOTAL-1). The frame always completes.
  - enable=0 sampled on the final counter cycle while in RUN: the controller finishes that frame and goes to IDLE.
- line_start is asserted when hc=0; frame_start is asserted when hc=0 and vc=0. Both are asserted only in RUN or DRAIN.
- Reset has priority over everything. Mid-frame it forces IDLE, zeroes the counters and drives all outputs inactive from the next edge. No frame completion occurs.

## Timing
- All outputs are registered and sit one cycle behind the counters. Sync, de, x, y and the pulses are mutually aligned with no skew.
- Latency: enable sampled high at edge E0 means de=1, x=0, y=0, frame_start=1 are visible after E1. running=1 is visible after E0.
- Reset values: hsync=~HSYNC_POL, vsync=~VSYNC_POL, de=0, x=0, y=0, line_start=0, frame_start=0, running=0.
- After the last pixel slot of a drained frame, the outputs go inactive on the next edge, and running=0 on that same edge.
- Defaults per line: 640 de cycles, then 16 porch cycles, then 96 hsync cycles starting 656 cycles after line_start, then 48 porch cycles. 800 cycles per line.
- Defaults per frame:
  - vsync asserted for lines 490–491, i.e. 1600 cycles.
  - 420000 cycles per frame.
  - 307200 de cycles per frame.

## Test plan
- Reset: hold reset 5 cycles with enable=1. All outputs are at their reset values; the first frame_start appears 2 edges after reset is released.
- Full frame at defaults:
  - exactly 307200 de cycles and 525 line_start pulses per frame
  - hsync low for 96 cycles starting 656 cycles after each line_start
  - vsync low for 1600 cycles
  - frame_start period of 420000 cycles
  - last de pixel has x=639, y=479
- Stop request: drop enable at line 100. Output continues to the end of the frame. running falls exactly 420000 cycles after that frame's frame_start, and no further pulses appear.
- Re-enable during DRAIN: drop enable at line 100 and raise it at line 300. The frame_start period stays exactly 420000 with no gap, and running stays high.
- Reset mid-frame at line 200 while running: outputs go inactive the next cycle. With enable held at 1 after release, the new frame starts at (0,0).
- Parameters: set HSYNC_POL=1, VSYNC_POL=1 and a small raster (H 8/2/3/2, V 4/1/2/1). Check sync active-high, H_TOTAL=15, V_TOTAL=8, and 32 de cycles per frame.
